// File: rtl/avst_packet_summer.sv
// avst_packet_summer: sums an Avalon-ST packet and re-emits the sum as a SUM_W/DATA_W-beat packet
// Optional build macro AVST_SUM_SAT_EN selects saturating accumulation instead of wrap-around.
module avst_packet_summer #(
  parameter int DATA_W    = 8,
  parameter int SUM_W     = 32,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_endofpacket,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_startofpacket,
  output logic              out_endofpacket,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int NBEATS = SUM_W / DATA_W;
  localparam int IDX_W  = NBEATS > 1 ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NBEATS - 1);
  typedef enum logic {ACCUM, EMIT} state_t;
  state_t state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d, hold_q, hold_d, acc;
  logic [IDX_W-1:0] k_q, k_d;
  logic [31:0] shift;
  generate
    if (SUM_W < DATA_W || SUM_W % DATA_W != 0) begin : g_chk
      $error("avst_packet_summer: SUM_W must be a nonzero multiple of DATA_W");
    end
  endgenerate
`ifdef AVST_SUM_SAT_EN
  logic [SUM_W:0] add;
  always_comb begin
    add = {1'b0, sum_q} + (SUM_W+1)'(in_data);
    acc = add[SUM_W] ? '1 : add[SUM_W-1:0];
  end
`else
  always_comb acc = sum_q + SUM_W'(in_data);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      hold_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      hold_q  <= hold_d;
      k_q     <= k_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    hold_d  = hold_q;
    k_d     = k_q;
    if (state_q == ACCUM) begin
      if (in_valid) begin
        sum_d = in_endofpacket ? '0 : acc;
        hold_d = in_endofpacket ? acc : hold_q;
        state_d = in_endofpacket ? EMIT : ACCUM;
      end
    end else if (out_ready) begin
      k_d = (k_q == K_LAST) ? '0 : k_q + IDX_W'(1);
      state_d = (k_q == K_LAST) ? ACCUM : EMIT;
    end
  end
  // beat k is taken from the top of the holding register down, or from the bottom up
  always_comb begin
    shift = (MSB_FIRST != 0) ? 32'(K_LAST - k_q) * DATA_W : 32'(k_q) * DATA_W;
    in_ready = state_q == ACCUM;
    out_valid = state_q == EMIT;
    out_startofpacket = out_valid && k_q == '0;
    out_endofpacket = out_valid && k_q == K_LAST;
    out_data = out_valid ? DATA_W'(hold_q >> shift) : '0;
  end
endmodule

// File: doc/avst_packet_summer.md
# avst_packet_summer

Parametrised Avalon-ST packet accumulator and serializer. It sums every data beat of an input packet into a SUM_W-bit accumulator. After end-of-packet it emits the sum as a new SUM_W/DATA_W-beat Avalon-ST packet with full valid/ready backpressure. It sits in the streaming datapath between a packet source and a downstream Avalon-ST sink, and replaces the fixed 8-bit/32-bit adder stage.

## Interface
- DATA_W, 8, beat width in bits (≥1).
- SUM_W, 32, accumulator width. Must be a multiple of DATA_W and ≥ DATA_W; an elaboration-time check errors otherwise.
- MSB_FIRST, 1, 1 = emit the most-significant beat first; 0 = emit the least-significant beat first.
- Derived: NBEATS = SUM_W/DATA_W; beat index width = max(1, clog2(NBEATS)).
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_data  in  DATA_W  input beat, unsigned.
- in_endofpacket  in  1  marks the last beat of the input packet.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- out_data  out  DATA_W  sum beat.
- out_startofpacket  out  1  first sum beat.
- out_endofpacket  out  1  last sum beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts the beat.

## Operation
- Two-state FSM: ACCUM and EMIT. Reset places the FSM in ACCUM.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, sum=0, beat index=0.
- ACCUM:
  - in_ready=1.
  - An input beat is accepted when in_valid && in_ready.
  - On acceptance: sum <= sum + zero-extended in_data, modulo 2^SUM_W (see Configuration for saturating mode).
  - If the accepted beat has in_endofpacket=1: load the output holding register with the final sum (including this beat), clear sum, and go to EMIT.
- EMIT:
  - in_ready=0; in_valid is ignored.
  - out_valid=1.
  - out_data = beat slice k of the holding register: bits [SUM_W-1-k·DATA_W -: DATA_W] when MSB_FIRST=1, or [k·DATA_W +: DATA_W] when MSB_FIRST=0.
  - out_startofpacket = (k==0); out_endofpacket = (k==NBEATS-1).
  - On out_valid && out_ready: k increments.
  - On the transfer with k==NBEATS-1: k clears and the FSM returns to ACCUM.
- While out_valid && !out_ready, out_data, out_startofpacket and out_endofpacket hold stable.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Single-beat packet (a beat arriving with in_endofpacket=1): the sum equals that beat.
- NBEATS=1: out_startofpacket and out_endofpacket are both 1 on the single output beat.
- Reset asserted in any state, including mid-EMIT, aborts the current packet. All state returns to reset values on the next edge, and no partial packet resumes.

## Timing
- An EOP beat accepted at edge N gives out_valid=1 and the first beat on out_data after edge N. in_ready=0 over the same interval.
- With out_ready held at 1, beats transfer on edges N+1 … N+NBEATS.
- in_ready returns to 1 after the edge carrying the last output transfer. A new packet's first beat can therefore be accepted one cycle after the final sum beat transfers.
- Minimum packet-to-packet period: L + NBEATS cycles, where L is the input packet length in beats.
- Throughput in ACCUM is one beat per cycle with no bubbles.

## Configuration
- AVST_SUM_SAT_EN defined: accumulation saturates. If sum + in_data ≥ 2^SUM_W, sum becomes 2^SUM_W-1 and stays there until the packet ends.
- AVST_SUM_SAT_EN undefined (default): accumulation wraps modulo 2^SUM_W.
- Ports and timing are identical in both builds.

## Test plan
- Basic sum, defaults, out_ready=1: input beats 0x01, 0x02, 0x03 (EOP on 0x03) → output 0x00, 0x00, 0x00, 0x06 on consecutive cycles. out_startofpacket is set on the first beat and out_endofpacket on the last. in_ready=0 for exactly 4 cycles.
- Backpressure: same packet with out_ready toggling 1,0,0,1,… → each beat is held stable while stalled. Exactly 4 transfers occur, and in_valid asserted during EMIT is not accepted.
- Overflow with DATA_W=8, SUM_W=8: input beats 0xF0, 0x20 (EOP) → a single output beat 0x10 with both out_startofpacket and out_endofpacket set. With AVST_SUM_SAT_EN defined, the output is 0xFF.
- LSB-first and back-to-back: MSB_FIRST=0, packet A = 0x12, 0x34 (EOP) immediately followed by packet B = 0xFF (EOP) → outputs 0x46, 0x00, 0x00, 0x00, then 0xFF, 0x00, 0x00, 0x00. Packet B's first beat is accepted the cycle after A's last output transfer, and the sum has no carry-over from A.
- Reset mid-EMIT: assert reset after the 2nd output beat → on the next edge out_valid=0, in_ready=1 and sum=0. A following packet 0x05 (EOP) yields 0x00, 0x00, 0x00, 0x05.
- Single-beat packet: input 0xAB with EOP → output 0x00, 0x00, 0x00, 0xAB, with first beat valid one cycle after acceptance.
